// File: rtl/glitch_pkg.sv
// Shared types and default sizes for the glitch sequencer and its counters.
package glitch_pkg;

    localparam int DEFAULT_DLY_W       = 24;
    localparam int DEFAULT_WID_W       = 16;
    localparam int DEFAULT_ARM_TIMEOUT = 16;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ARMED        = 3'd1,
        WAIT_RELEASE = 3'd2,
        DELAY        = 3'd3,
        PULSE        = 3'd4,
        GAP          = 3'd5,
        DONE         = 3'd6
    } state_t;

endpackage

// File: rtl/glitch_down_counter.sv
// Load/decrement counter that saturates at zero and flags when it is empty.
module glitch_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// Arms a target reset, waits for its release, then emits N pulses of W cycles
// separated by max(G,1) low cycles, the first rising D+1 cycles after release.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DLY_W       = DEFAULT_DLY_W,
    parameter int WID_W       = DEFAULT_WID_W,
    parameter int ARM_TIMEOUT = DEFAULT_ARM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [DLY_W-1:0] delay_cycles,
    input  logic [WID_W-1:0] width_cycles,
    input  logic [WID_W-1:0] gap_cycles,
    input  logic [7:0]       pulse_count,
    input  logic             abort,
    input  logic             reset_line,
    output logic             reset_req,
    output logic             glitch_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output state_t           state
);

    localparam int TMO_W = $clog2(ARM_TIMEOUT + 1);

    logic [DLY_W-1:0] sh_delay;
    logic [WID_W-1:0] sh_width;
    logic [WID_W-1:0] sh_gap;
    logic [7:0]       sh_count;
    logic [TMO_W-1:0] tmo_cnt;

    logic             dly_load, dly_dec, dly_zero;
    logic             wg_load, wg_dec, wg_zero;
    logic [WID_W-1:0] wg_value;
    logic             pc_load, pc_dec, pc_zero;

    logic             cfg_ok;
    logic             run_ok;
    logic [WID_W-1:0] width_load;
    logic [WID_W-1:0] gap_load;

    assign cfg_ok     = (width_cycles != '0) && (pulse_count != 8'd0);
    assign run_ok     = !abort && !reset_line;
    assign width_load = sh_width - WID_W'(1);
    // A zero gap still leaves one low cycle so consecutive pulses stay distinct.
    assign gap_load   = (sh_gap == '0) ? '0 : sh_gap - WID_W'(1);

    always_comb begin
        dly_load = 1'b0;
        dly_dec  = 1'b0;
        wg_load  = 1'b0;
        wg_dec   = 1'b0;
        wg_value = width_load;
        pc_load  = 1'b0;
        pc_dec   = 1'b0;
        case (state)
            WAIT_RELEASE: begin
                if (run_ok) begin
                    dly_load = 1'b1;
                    pc_load  = 1'b1;
                end
            end
            DELAY: begin
                if (run_ok) begin
                    if (dly_zero) wg_load = 1'b1;
                    else          dly_dec = 1'b1;
                end
            end
            PULSE: begin
                if (run_ok) begin
                    if (wg_zero) begin
                        if (!pc_zero) begin
                            pc_dec   = 1'b1;
                            wg_load  = 1'b1;
                            wg_value = gap_load;
                        end
                    end else begin
                        wg_dec = 1'b1;
                    end
                end
            end
            GAP: begin
                if (run_ok) begin
                    if (wg_zero) wg_load = 1'b1;
                    else         wg_dec  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    glitch_down_counter #(.WIDTH(DLY_W)) u_delay_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (dly_load),
        .dec   (dly_dec),
        .value (sh_delay),
        .zero  (dly_zero)
    );

    glitch_down_counter #(.WIDTH(WID_W)) u_width_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (wg_load),
        .dec   (wg_dec),
        .value (wg_value),
        .zero  (wg_zero)
    );

    glitch_down_counter #(.WIDTH(8)) u_pulse_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (pc_load),
        .dec   (pc_dec),
        .value (sh_count - 8'd1),
        .zero  (pc_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            reset_req  <= 1'b0;
            glitch_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tmo_cnt    <= '0;
            sh_delay   <= '0;
            sh_width   <= '0;
            sh_gap     <= '0;
            sh_count   <= 8'd0;
        end else begin
            reset_req <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if ((state != IDLE) && abort) begin
                state      <= IDLE;
                busy       <= 1'b0;
                glitch_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            if (!cfg_ok) begin
                                err <= 1'b1;
                            end else begin
                                sh_delay  <= delay_cycles;
                                sh_width  <= width_cycles;
                                sh_gap    <= gap_cycles;
                                sh_count  <= pulse_count;
                                reset_req <= 1'b1;
                                tmo_cnt   <= TMO_W'(ARM_TIMEOUT - 1);
                                busy      <= 1'b1;
                                state     <= ARMED;
                            end
                        end
                    end
                    ARMED: begin
                        if (reset_line) begin
                            state <= WAIT_RELEASE;
                        end else if (tmo_cnt == '0) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt - TMO_W'(1);
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!reset_line) state <= DELAY;
                    end
                    DELAY, PULSE, GAP: begin
                        // A re-asserted target reset restarts the whole train.
                        if (reset_line) begin
                            glitch_out <= 1'b0;
                            state      <= WAIT_RELEASE;
                        end else if (state == DELAY) begin
                            if (dly_zero) begin
                                glitch_out <= 1'b1;
                                state      <= PULSE;
                            end
                        end else if (state == PULSE) begin
                            if (wg_zero) begin
                                glitch_out <= 1'b0;
                                if (pc_zero) begin
                                    done  <= 1'b1;
                                    state <= DONE;
                                end else begin
                                    state <= GAP;
                                end
                            end
                        end else if (wg_zero) begin
                            glitch_out <= 1'b1;
                            state      <= PULSE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        glitch_out <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/glitch_sequencer.md
GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

Interface
REQ-001 The block SHALL have parameter DLY_W, default 24, giving the delay counter width in bits.
REQ-002 The block SHALL have parameter WID_W, default 16, giving the pulse width and gap counter width in bits.
REQ-003 The block SHALL have parameter ARM_TIMEOUT, default 16, giving the maximum cycles to wait for reset_line high after reset_req.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port arm, input, 1 bit: start request, sampled in IDLE only.
REQ-007 Port delay_cycles, input, DLY_W bits: release-to-first-pulse delay D.
REQ-008 Port width_cycles, input, WID_W bits: pulse high time W.
REQ-009 Port gap_cycles, input, WID_W bits: low time G between pulses.
REQ-010 Port pulse_count, input, 8 bits: number of pulses N.
REQ-011 Port abort, input, 1 bit: cancels any sequence in progress.
REQ-012 Port reset_line, input, 1 bit: target reset from the resetter stage, in the same clock domain.
REQ-013 Port reset_req, output, 1 bit: single-cycle enable pulse to the resetter stage.
REQ-014 Port glitch_out, output, 1 bit: registered glitch pulse.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port done, output, 1 bit: single-cycle pulse when a sequence completes.
REQ-017 Port err, output, 1 bit: single-cycle pulse on a configuration error or an arm timeout.

Function
REQ-018 The state machine SHALL have states IDLE, ARMED, WAIT_RELEASE, DELAY, PULSE, GAP and DONE.
REQ-019 In IDLE with arm=1, the block SHALL latch D, W, G and N into shadow registers, pulse reset_req for one cycle and enter ARMED; inputs are not sampled again until IDLE.
REQ-020 In IDLE with arm=1 and W=0 or N=0, the block SHALL pulse err for one cycle, SHALL NOT pulse reset_req and SHALL stay in IDLE.
REQ-021 In ARMED, reset_line=1 SHALL move the block to WAIT_RELEASE.
REQ-022 If reset_line is not seen high within ARM_TIMEOUT cycles of entering ARMED, the block SHALL pulse err and return to IDLE.
REQ-023 In WAIT_RELEASE, the first edge E0 at which reset_line=0 is sampled SHALL load the delay counter with D and enter DELAY.
REQ-024 glitch_out SHALL first rise at edge E0+D+1; D=0 therefore gives a rise at E0+1.
REQ-025 Each pulse SHALL hold glitch_out high for exactly W cycles.
REQ-026 Consecutive pulses SHALL be separated by exactly max(G,1) low cycles.
REQ-027 The block SHALL emit exactly N pulses, with no gap after the last one.
REQ-028 On the edge after the last pulse ends, the block SHALL drop glitch_out, pulse done (in DONE) for one cycle and then return to IDLE.
REQ-029 Counters SHALL be load-and-decrement, with a state transition on count==0, and SHALL never wrap.
REQ-030 The maximum values D=2^DLY_W-1, W=2^WID_W-1 and N=255 SHALL work without overflow.
REQ-031 reset_line=1 during DELAY, PULSE or GAP SHALL force glitch_out low on the next edge, reload N and return the block to WAIT_RELEASE (re-synchronise to the next release), with no done and no err.
REQ-032 abort=1 in any non-IDLE state SHALL force glitch_out low on the next edge and return the block to IDLE, with no done and no err.
REQ-033 abort SHALL take priority over reset_line, which SHALL take priority over counter expiry.
REQ-034 arm while busy=1 SHALL be ignored.
REQ-035 abort in IDLE SHALL have no effect.
REQ-036 done and err SHALL never be asserted in the same cycle.

Reset
REQ-037 rst=1 SHALL put the block in IDLE on the next edge, from any state, with higher priority than abort.
REQ-038 Under reset, glitch_out, reset_req, busy, done and err SHALL be 0, and all counters and shadow registers SHALL be 0.
REQ-039 rst asserted mid-pulse SHALL drop glitch_out on the same edge that enters IDLE.

Structure
REQ-040 Package glitch_pkg SHALL hold the state enumeration, the default widths and ARM_TIMEOUT.
REQ-041 Sub-module glitch_down_counter SHALL be a parameterised load/decrement counter with a zero flag, instantiated for the delay, the width/gap and the pulse count.
REQ-042 All outputs SHALL be registered.

Verification
REQ-043 arm with D=5, W=3, G=2, N=2, reset_line high for 10 cycles then low at E0 -> glitch_out high during E0+6..E0+8, low for 2 cycles, high during E0+11..E0+13, done at E0+14.
REQ-044 D=0, W=1, N=1 -> a single 1-cycle pulse rising at E0+1, and done one cycle after it.
REQ-045 arm with W=0 -> err pulse, no reset_req, busy stays 0.
REQ-046 reset_line never rises after arm -> err pulse after 16 cycles and return to IDLE.
REQ-047 reset_line reasserted during the second pulse -> glitch_out low on the next edge, and a full N-pulse sequence after the next release.
REQ-048 abort during DELAY, and rst during PULSE -> IDLE, glitch_out=0, no done, and a second arm accepted afterwards.
